pipeline_stall_controller: RTL and testbench

//  Central freeze/flush sequencer for the 5-stage pipeline. Merges three inputs into per-stage

---
 rtl/pipeline_stall_controller.sv | 151 +++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_controller
//  Description : Central freeze/flush sequencer for the 5-stage pipeline.
//                Merges three inputs into per-stage freeze, flush and bubble
//                controls:
//                  - load-use hazards from the hazard unit
//                  - taken branches resolved in EXE
//                  - multi-cycle SRAM accesses issued from MEM
//                Contains the SRAM wait FSM with a timeout watchdog, and
//                saturating stall and flush performance counters.
//  Ports       : clk, rst (async, active-high)
//                hazard_detected, branch_taken, mem_req, mem_ready, cnt_clear
//                mem_start, freeze_all, pc_freeze, IF_ID_freeze, ID_bubble,
//                IF_flush, ID_flush, mem_error, stall_count, flush_count
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clear,
    output logic             mem_start,
    output logic             freeze_all,
    output logic             pc_freeze,
    output logic             IF_ID_freeze,
    output logic             ID_bubble,
    output logic             IF_flush,
    output logic             ID_flush,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                  c_WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_ST_ERROR    = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_next;
    logic                w_mem_start;
    logic                w_freeze_all;
    logic                w_flush;
    logic                w_stall;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    // SRAM access sequencing
    always_comb begin
        w_next_state = r_state;
        w_wait_next  = r_wait_cnt;
        w_mem_start  = 1'b0;
        w_freeze_all = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                w_wait_next = '0;
                if (mem_req) begin
                    w_mem_start = 1'b1;
                    // A zero-wait access completes in the launch cycle and
                    // never leaves RUN.
                    if (!mem_ready) begin
                        w_freeze_all = 1'b1;
                        w_next_state = c_ST_MEM_WAIT;
                    end
                end
            end
            c_ST_MEM_WAIT: begin
                // mem_req is deliberately not looked at here: an early drop
                // must not abandon an access already in flight.
                w_freeze_all = !mem_ready;
                if (mem_ready) begin
                    w_next_state = c_ST_RUN;
                    w_wait_next  = '0;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_next_state = c_ST_ERROR;
                    w_wait_next  = '0;
                end else begin
                    w_wait_next = r_wait_cnt + 1'b1;
                end
            end
            c_ST_ERROR: begin
                w_freeze_all = 1'b1;
            end
            default: begin
                w_next_state = c_ST_RUN;
                w_wait_next  = '0;
            end
        endcase
    end

    // A global freeze masks both branch and hazard; they are re-evaluated once
    // the pipeline moves again. A taken branch squashes the younger
    // instruction, so it overrides the hazard.
    assign w_flush = !w_freeze_all && branch_taken;
    assign w_stall = !w_freeze_all && !branch_taken && hazard_detected;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_next;
        end
    end

    // Performance counters: clear beats increment, saturate at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clear) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((w_freeze_all || w_stall) && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // Controls are combinational, so they are gated explicitly to stay low
    // for the whole time reset is asserted.
    assign mem_start    = !rst && w_mem_start;
    assign freeze_all   = !rst && w_freeze_all;
    assign pc_freeze    = !rst && w_stall;
    assign IF_ID_freeze = !rst && w_stall;
    assign ID_bubble    = !rst && w_stall;
    assign IF_flush     = !rst && w_flush;
    assign ID_flush     = !rst && w_flush;
    assign mem_error    = !rst && (r_state == c_ST_ERROR);
    assign stall_count  = r_stall_cnt;
    assign flush_count  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_stall_controller
//  Description : Self-checking bench for pipeline_stall_controller. Each cycle
//                drives one vector, pushes the expected controls and counter
//                values to a scoreboard queue, then pops and compares mid-cycle.
//                Counter expectations are accumulated from the expected control
//                bits of each vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 16;

    // Control bit order: {mem_start, freeze_all, pc_freeze, IF_ID_freeze,
    //                     ID_bubble, IF_flush, ID_flush, mem_error}
    localparam logic [7:0] K_NONE  = 8'h00;
    localparam logic [7:0] K_START = 8'h80;
    localparam logic [7:0] K_FRZ   = 8'h40;
    localparam logic [7:0] K_HAZ   = 8'h38;
    localparam logic [7:0] K_BR    = 8'h06;
    localparam logic [7:0] K_ERR   = 8'h41;

    logic             clk = 1'b0;
    logic             rst;
    logic             hazard_detected;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             cnt_clear;
    logic             mem_start;
    logic             freeze_all;
    logic             pc_freeze;
    logic             IF_ID_freeze;
    logic             ID_bubble;
    logic             IF_flush;
    logic             ID_flush;
    logic             mem_error;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    always #5 clk = ~clk;

    pipeline_stall_controller #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hazard_detected(hazard_detected),
        .branch_taken   (branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .cnt_clear      (cnt_clear),
        .mem_start      (mem_start),
        .freeze_all     (freeze_all),
        .pc_freeze      (pc_freeze),
        .IF_ID_freeze   (IF_ID_freeze),
        .ID_bubble      (ID_bubble),
        .IF_flush       (IF_flush),
        .ID_flush       (ID_flush),
        .mem_error      (mem_error),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    typedef struct {
        logic       hz;
        logic       br;
        logic       mreq;
        logic       mrdy;
        logic       clr;
        logic [7:0] ctl;
    } vec_t;

    typedef struct {
        string            name;
        logic [7:0]       ctl;
        logic [CNT_W-1:0] s;
        logic [CNT_W-1:0] f;
    } exp_t;

    exp_t             sb[$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] m_s   = '0;
    logic [CNT_W-1:0] m_f   = '0;

    function automatic vec_t mk(logic hz, logic br, logic mreq, logic mrdy,
                                logic clr, logic [7:0] ctl);
        vec_t v;
        v.hz   = hz;
        v.br   = br;
        v.mreq = mreq;
        v.mrdy = mrdy;
        v.clr  = clr;
        v.ctl  = ctl;
        return v;
    endfunction

    task automatic push_exp(string name, logic [7:0] ctl);
        exp_t e;
        e.name = name;
        e.ctl  = ctl;
        e.s    = m_s;
        e.f    = m_f;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t       e;
        logic [7:0] act;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e   = sb.pop_front();
        act = {mem_start, freeze_all, pc_freeze, IF_ID_freeze, ID_bubble,
               IF_flush, ID_flush, mem_error};
        n_vec++;
        if (act !== e.ctl || stall_count !== e.s || flush_count !== e.f) begin
            n_err++;
            $display("FAIL %s: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                     e.name, act, stall_count, flush_count, e.ctl, e.s, e.f);
        end
    endtask

    // Called just after a falling edge: drive, check mid-cycle, then advance.
    task automatic step(string name, vec_t v);
        hazard_detected = v.hz;
        branch_taken    = v.br;
        mem_req         = v.mreq;
        mem_ready       = v.mrdy;
        cnt_clear       = v.clr;
        push_exp(name, v.ctl);
        if (v.clr) begin
            m_s = '0;
            m_f = '0;
        end else begin
            if ((v.ctl[6] || v.ctl[5]) && m_s != '1) m_s = m_s + 1'b1;
            if (v.ctl[2] && m_f != '1) m_f = m_f + 1'b1;
        end
        #1;
        compare();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset(string name);
        m_s = '0;
        m_f = '0;
        push_exp(name, K_NONE);
        #1;
        compare();
    endtask

    vec_t tbl[9];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = mk(0, 0, 0, 0, 0, K_NONE);
        tbl[1] = mk(1, 0, 0, 0, 0, K_HAZ);
        tbl[2] = mk(1, 1, 0, 0, 0, K_BR);
        tbl[3] = mk(0, 1, 0, 0, 0, K_BR);
        tbl[4] = mk(0, 0, 1, 1, 0, K_START);
        tbl[5] = mk(0, 1, 1, 1, 0, K_START | K_BR);
        tbl[6] = mk(1, 0, 1, 1, 0, K_START | K_HAZ);
        tbl[7] = mk(1, 0, 0, 0, 1, K_HAZ);
        tbl[8] = mk(0, 0, 0, 0, 0, K_NONE);

        // Reset with every request input active: all controls held low
        rst             = 1'b1;
        hazard_detected = 1'b1;
        branch_taken    = 1'b1;
        mem_req         = 1'b1;
        mem_ready       = 1'b0;
        cnt_clear       = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset_state");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            step($sformatf("table_%0d", i), tbl[i]);
        end

        // Four-cycle SRAM wait; branch and hazard are masked while frozen and
        // an early mem_req drop does not end the wait
        step("wait_launch",    mk(0, 0, 1, 0, 0, K_START | K_FRZ));
        step("wait_branch",    mk(0, 1, 1, 0, 0, K_FRZ));
        step("wait_hazard",    mk(1, 0, 1, 0, 0, K_FRZ));
        step("wait_req_drop",  mk(0, 0, 0, 0, 0, K_FRZ));
        step("wait_ready",     mk(0, 0, 1, 1, 0, K_NONE));
        step("post_branch",    mk(0, 1, 0, 0, 0, K_BR));
        step("post_idle",      mk(0, 0, 0, 0, 0, K_NONE));

        // Asynchronous reset in the middle of a wait
        step("rst_launch",     mk(0, 0, 1, 0, 0, K_START | K_FRZ));
        step("rst_wait1",      mk(0, 0, 1, 0, 0, K_FRZ));
        step("rst_wait2",      mk(0, 0, 1, 0, 0, K_FRZ));
        hazard_detected = 1'b1;
        branch_taken    = 1'b1;
        mem_req         = 1'b1;
        mem_ready       = 1'b0;
        #2;
        rst = 1'b1;
        check_reset("rst_async");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step("rst_back_in_run", mk(0, 0, 1, 1, 0, K_START));
        step("rst_idle",        mk(0, 0, 0, 0, 0, K_NONE));

        // Ready arriving on the last allowed wait cycle completes normally
        step("edge_launch",    mk(0, 0, 1, 0, 0, K_START | K_FRZ));
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
            step($sformatf("edge_wait_%0d", i), mk(0, 0, 1, 0, 0, K_FRZ));
        end
        step("edge_ready_last", mk(0, 0, 1, 1, 0, K_NONE));
        step("edge_still_run",  mk(0, 0, 1, 1, 0, K_START));
        step("edge_idle",       mk(0, 0, 0, 0, 0, K_NONE));

        // Timeout into ERROR
        step("to_launch",      mk(0, 0, 1, 0, 0, K_START | K_FRZ));
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            step($sformatf("to_wait_%0d", i), mk(0, 0, 1, 0, 0, K_FRZ));
        end
        step("to_error",        mk(0, 0, 1, 0, 0, K_ERR));
        step("to_error_ignore", mk(1, 1, 1, 1, 0, K_ERR));

        // Long run in ERROR drives stall_count into saturation
        for (int i = 0; i < 65600; i++) begin
            step("sat_run", mk(0, 0, 0, 0, 0, K_ERR));
        end
        step("sat_hold",  mk(1, 1, 0, 0, 0, K_ERR));
        step("err_clear", mk(0, 0, 0, 0, 1, K_ERR));
        step("err_after_clear0", mk(0, 0, 0, 0, 0, K_ERR));
        step("err_after_clear1", mk(0, 0, 0, 0, 0, K_ERR));

        // Reset is the only way out of ERROR
        rst = 1'b1;
        check_reset("err_reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step("final_run", mk(0, 0, 1, 1, 0, K_START));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
